freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measures the frequency of an external or internally generated square wave, such as a divided clock output, against the 50 MHz board clock.
- Counts rising edges of the input over a fixed gate window of GATE_CYCLES clock cycles, then latches the result with a one-cycle valid strobe.
- Serves as the self-check counterpart to the clock-divider chain: divided clocks are looped back into sig_in and their rates are read out on the LEDs or 7-segment display.

Parameters:
- GATE_CYCLES, 50000000, length of the measurement window in clk cycles; must be ≥ 2. The default gives 1 s at 50 MHz, so the result reads directly in Hz.
- CNT_W, 28, width of the edge counter and of the result. The count saturates at 2^CNT_W-1.
- GATE_W, 26, width of the gate down-counter; must satisfy 2^GATE_W > GATE_CYCLES-1.

Ports:
- clk  input  1  system clock (MAX10_CLK1_50 at top level)
- rst_n  input  1  asynchronous, active-low reset
- sig_in  input  1  signal under measurement; asynchronous to clk
- start  input  1  request a single measurement; sampled only in IDLE
- cont  input  1  continuous mode; 1 = re-arm automatically after each window
- busy  output  1  high while in MEASURE
- freq  output  CNT_W  edge count of the last completed window
- ovf  output  1  the last completed window saturated the counter
- valid  output  1  one-cycle strobe when freq and ovf update

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, freq=0, ovf=0, valid=0.
  - Both synchronizer flops, the edge-detect flop, the edge counter and the gate counter are cleared.
  - Reset mid-window discards the measurement; no valid pulse is produced.
- Input path:
  - Two-flop synchronizer, then a registered previous value.
  - edge = sync_q & ~prev_q, asserted one cycle per rising edge.
  - Latency from a sig_in rise to edge is 2-3 clk cycles.
  - Pulses shorter than one clk period may be missed; this is accepted.
- State machine, IDLE:
  - busy=0; edges are ignored.
  - If start=1 or cont=1: gate <= GATE_CYCLES-1, cnt <= 0, sat <= 0, go to MEASURE.
- State machine, MEASURE:
  - busy=1.
  - Each cycle: if edge, cnt <= cnt+1 unless cnt == 2^CNT_W-1; in that case cnt holds and sat <= 1.
  - If gate != 0: gate <= gate-1.
  - If gate == 0 (terminal cycle):
    - freq <= final count including this cycle's edge, saturated.
    - ovf <= saturation flag, including saturation caused in this cycle.
    - valid <= 1 for exactly the next cycle.
    - If cont=1: reload gate and clear cnt and sat in the same edge; stay in MEASURE with no dead cycle between windows.
    - Otherwise go to IDLE.
- Timing:
  - With start sampled high in IDLE at cycle t, the window covers cycles t+1 .. t+GATE_CYCLES.
  - valid is high at cycle t+GATE_CYCLES+1.
  - Each window counts edges in exactly GATE_CYCLES cycles.
- Handshake rules:
  - start while busy is ignored; it is neither queued nor restarts the window.
  - Deasserting cont mid-window lets the current window finish normally, then the block returns to IDLE.
  - freq and ovf hold their values between valid pulses.
  - valid is never asserted for two consecutive cycles unless GATE_CYCLES=1, which is disallowed.
- Widths:
  - gate is GATE_W bits unsigned.
  - cnt and freq are CNT_W bits unsigned and never wrap.

Test Plan:
- Reset check (GATE_CYCLES=100): assert rst_n=0 with sig_in toggling -> busy=0, freq=0, ovf=0, valid=0. Release reset with start=0 for 500 cycles -> valid never asserts.
- Single window (GATE_CYCLES=100): sig_in square wave with period 10 clk, start pulse at cycle t -> busy high t+1..t+100, valid only at t+101, freq=10 (±1 for phase), ovf=0. Then returns to IDLE.
- DC input: sig_in held at 1 across the window -> freq=0. Repeat with sig_in held at 0 -> freq=0.
- Saturation (CNT_W=4, GATE_CYCLES=100): sig_in toggles every clk cycle from a clock-aligned source (about 50 edges) -> freq=15, ovf=1. Next window with a 10-cycle period -> freq=10, ovf=0.
- Continuous mode (GATE_CYCLES=100, cont=1): valid pulses exactly 100 cycles apart and busy never drops. Sum of 5 freq readings equals the total synchronized edges in 500 cycles. Drop cont mid-window -> that window completes, then IDLE.
- Disturbances: start pulses during MEASURE -> window length unchanged. rst_n=0 at cycle 50 of a window -> all outputs 0 immediately and asynchronously, no valid. Fresh start afterwards -> correct count.

Source files
------------

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed
// gate window of GATE_CYCLES clk cycles. At the end of each window it latches
// the saturated count into freq and the overflow flag into ovf, and pulses
// valid for one cycle. With cont=1 the next window starts immediately after
// the previous one, so no input cycle goes unobserved.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 28,
  parameter int GATE_W      = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             ovf,
  output logic             valid
);

  // The gate counter is loaded with GATE_CYCLES-1 and counts down to zero.
  // The cycle in which it reads zero is the last cycle of the window, which
  // gives exactly GATE_CYCLES counted cycles per window.
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  // Input path: two-flop synchronizer, then a delayed copy for edge detection.
  logic sync_meta;
  logic sync_q;
  logic prev_q;
  logic edge_pulse;

  // Measurement registers and their next-state values.
  logic [GATE_W-1:0] gate;
  logic [GATE_W-1:0] gate_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              sat;
  logic              sat_nxt;
  logic [CNT_W-1:0]  freq_nxt;
  logic              ovf_nxt;
  logic              valid_nxt;

  // Count and saturation flag as they stand after this cycle's edge, used
  // both for ordinary counting and for the terminal-cycle result.
  logic [CNT_W-1:0]  cnt_upd;
  logic              sat_upd;

  // Bring the asynchronous input into the clk domain and keep one cycle of
  // history so that a rising edge gives a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sync_q    <= sync_meta;
      prev_q    <= sync_q;
    end
  end

  assign edge_pulse = sync_q & ~prev_q;

  // Saturating increment: once the counter is full it holds its value, and
  // the sticky flag records that edges were lost.
  always_comb begin
    cnt_upd = cnt;
    sat_upd = sat;
    if (edge_pulse) begin
      if (cnt == CNT_MAX) begin
        sat_upd = 1'b1;
      end else begin
        cnt_upd = cnt + CNT_ONE;
      end
    end
  end

  // State register for the IDLE/MEASURE controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath decisions. In IDLE edges are ignored and a
  // start or cont request arms a fresh window. In MEASURE every cycle is
  // counted; the terminal cycle publishes the result and either re-arms in
  // the same edge (cont) or returns to IDLE.
  always_comb begin
    next_state = state;
    gate_nxt   = gate;
    cnt_nxt    = cnt;
    sat_nxt    = sat;
    freq_nxt   = freq;
    ovf_nxt    = ovf;
    valid_nxt  = 1'b0;
    busy       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start || cont) begin
          gate_nxt   = GATE_LOAD;
          cnt_nxt    = '0;
          sat_nxt    = 1'b0;
          next_state = MEASURE;
        end
      end

      MEASURE: begin
        busy    = 1'b1;
        cnt_nxt = cnt_upd;
        sat_nxt = sat_upd;
        if (gate != '0) begin
          gate_nxt = gate - GATE_ONE;
        end else begin
          freq_nxt  = cnt_upd;
          ovf_nxt   = sat_upd;
          valid_nxt = 1'b1;
          if (cont) begin
            gate_nxt = GATE_LOAD;
            cnt_nxt  = '0;
            sat_nxt  = 1'b0;
          end else begin
            next_state = IDLE;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Measurement registers. A reset in the middle of a window throws the
  // partial count away and leaves the published result cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate  <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      gate  <= gate_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
      freq  <= freq_nxt;
      ovf   <= ovf_nxt;
      valid <= valid_nxt;
    end
  end

endmodule
